// File: rtl/irq_pending_ctrl_pkg.sv
// rtl/irq_pending_ctrl_pkg.sv - shared widths, FSM encoding and encoder-check helpers
package irq_pending_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

  // Encoder answer is trusted only if it names a set bit with nothing set above it.
  function automatic logic enc_index_ok(input logic [NUM_REQ-1:0] vec,
                                        input logic [ID_W-1:0]    idx);
    enc_index_ok = vec[idx];
    for (int n = 0; n < NUM_REQ; n++) begin
      if (n > int'(idx) && vec[n]) enc_index_ok = 1'b0;
    end
  endfunction

endpackage

// File: rtl/req_sync.sv
// rtl/req_sync.sv - multi-flop synchroniser for a vector of asynchronous lines
module req_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - request sync, edge capture, sticky pending and encoder-driven issue
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] enc_i,
  output logic               enc_p,
  input  logic [ID_W-1:0]    enc_o,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ready,
  output logic [NUM_REQ-1:0] pend,
  output logic               overflow,
  output logic               enc_err,
  input  logic               clr_sticky
);

  logic [NUM_REQ-1:0] sync_q;
  logic [NUM_REQ-1:0] prev_q;
  logic [NUM_REQ-1:0] pend_q;
  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] req_vec;
  logic               any_req;
  logic               accept;
  logic               enc_ok;
  logic               ovf_set;
  logic               err_set;
  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               ovf_q, err_q;

  req_sync #(
    .WIDTH      (NUM_REQ),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (req_in),
    .q    (sync_q)
  );

  assign rise    = sync_q & ~prev_q;
  assign req_vec = pend_q & ~mask;
  assign any_req = |req_vec;
  assign accept  = (state_q == ISSUE) && irq_ready;
  assign clr     = accept ? id_onehot(id_q) : '0;
  assign enc_ok  = enc_index_ok(req_vec, enc_o);
  // A rise landing on the bit being accepted simply re-arms it; not an overflow.
  assign ovf_set = |(rise & pend_q & ~clr);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (enc_ok) begin
            id_d    = enc_o;
            state_d = ISSUE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (irq_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      prev_q  <= sync_q;
      pend_q  <= (pend_q & ~clr) | rise;
      if (clr_sticky)   ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (clr_sticky)   err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  assign enc_i     = req_vec;
  assign enc_p     = any_req;
  assign irq_valid = (state_q == ISSUE);
  assign irq_id    = id_q;
  assign pend      = pend_q;
  assign overflow  = ovf_q;
  assign enc_err   = err_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - directed self-checking bench for irq_pending_ctrl
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_in = '0;
  logic [3:0] mask = '0;
  logic [3:0] enc_i;
  logic       enc_p;
  logic [1:0] enc_o;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ready = 1'b0;
  logic [3:0] pend;
  logic       overflow;
  logic       enc_err;
  logic       clr_sticky = 1'b0;

  logic       stub_en = 1'b0;
  logic [1:0] stub_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Priority encoder in loop (i3 highest), with an override for fault injection
  always_comb begin
    if (stub_en)       enc_o = stub_val;
    else if (enc_i[3]) enc_o = 2'd3;
    else if (enc_i[2]) enc_o = 2'd2;
    else if (enc_i[1]) enc_o = 2'd1;
    else               enc_o = 2'd0;
  end

  irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .enc_i     (enc_i),
    .enc_p     (enc_p),
    .enc_o     (enc_o),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
    .pend      (pend),
    .overflow  (overflow),
    .enc_err   (enc_err),
    .clr_sticky(clr_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the lines for two edges; returns just after the edge that registers the rise.
  task automatic pulse_req(input logic [3:0] v);
    req_in = v;
    tick();
    tick();
    req_in = '0;
    tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req_in = 4'b0100;
    tick();
    tick();
    checks++;
    if (pend !== 4'b0000 || irq_valid !== 1'b0 || irq_id !== 2'd0 || overflow !== 1'b0 || enc_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pend=%b valid=%b id=%0d ovf=%b err=%b expected all zero", pend, irq_valid, irq_id, overflow, enc_err);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pend_early: pend=%b expected 0000", pend);
    end
    tick();
    checks++;
    if (pend !== 4'b0100 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pend_set: pend=%b valid=%b expected 0100/0", pend, irq_valid);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin
      errors++;
      $display("FAIL reset_issue: valid=%b id=%0d expected 1/2", irq_valid, irq_id);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++;
    if (pend !== 4'b0000 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_accept: pend=%b valid=%b expected 0000/0", pend, irq_valid);
    end
    repeat (3) tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL reset_no_reissue: valid=%b pend=%b expected 0/0000", irq_valid, pend);
    end
    req_in = '0;
    repeat (3) tick();
  endtask

  task automatic test_priority_order();
    logic [1:0] ids [3]   = '{2'd3, 2'd1, 2'd0};
    logic [3:0] pends [3] = '{4'b0011, 4'b0001, 4'b0000};
    pulse_req(4'b1011);
    checks++;
    if (pend !== 4'b1011) begin
      errors++;
      $display("FAIL multi_pend: pend=%b expected 1011", pend);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== ids[k]) begin
        errors++;
        $display("FAIL multi_issue%0d: valid=%b id=%0d expected 1/%0d", k, irq_valid, irq_id, ids[k]);
      end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      checks++;
      if (pend !== pends[k] || irq_valid !== 1'b0) begin
        errors++;
        $display("FAIL multi_accept%0d: pend=%b valid=%b expected %b/0", k, pend, irq_valid, pends[k]);
      end
    end
    repeat (2) tick();
    checks++;
    if (irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_idle: valid=%b expected 0", irq_valid);
    end
  endtask

  task automatic test_mask();
    mask = 4'b1000;
    pulse_req(4'b1001);
    checks++;
    if (pend !== 4'b1001 || enc_i !== 4'b0001 || enc_p !== 1'b1) begin
      errors++;
      $display("FAIL mask_enc: pend=%b enc_i=%b enc_p=%b expected 1001/0001/1", pend, enc_i, enc_p);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin
      errors++;
      $display("FAIL mask_issue0: valid=%b id=%0d expected 1/0", irq_valid, irq_id);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (pend !== 4'b1000 || irq_valid !== 1'b0 || enc_p !== 1'b0) begin
      errors++;
      $display("FAIL mask_hold: pend=%b valid=%b enc_p=%b expected 1000/0/0", pend, irq_valid, enc_p);
    end
    mask = 4'b0000;
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd3) begin
      errors++;
      $display("FAIL mask_issue3: valid=%b id=%0d expected 1/3", irq_valid, irq_id);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL mask_accept3: pend=%b expected 0000", pend);
    end
    tick();
  endtask

  task automatic test_overflow();
    pulse_req(4'b0010);
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: valid=%b id=%0d ovf=%b expected 1/1/0", irq_valid, irq_id, overflow);
    end
    pulse_req(4'b0010);
    checks++;
    if (overflow !== 1'b1 || pend !== 4'b0010 || irq_valid !== 1'b1 || irq_id !== 2'd1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b pend=%b valid=%b id=%0d expected 1/0010/1/1", overflow, pend, irq_valid, irq_id);
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_accept: pend=%b expected 0000", pend);
    end
    tick();
  endtask

  task automatic test_set_clr_same();
    pulse_req(4'b0100);
    tick();
    req_in = 4'b0100;
    tick();
    tick();
    irq_ready = 1'b1;
    req_in    = 4'b0000;
    tick();
    irq_ready = 1'b0;
    checks++;
    if (pend !== 4'b0100 || overflow !== 1'b0 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL setclr_same: pend=%b ovf=%b valid=%b expected 0100/0/0", pend, overflow, irq_valid);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin
      errors++;
      $display("FAIL setclr_reissue: valid=%b id=%0d expected 1/2", irq_valid, irq_id);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL setclr_accept: pend=%b expected 0000", pend);
    end
    tick();
  endtask

  task automatic test_enc_err_and_reset();
    stub_en  = 1'b1;
    stub_val = 2'd1;
    pulse_req(4'b0100);
    tick();
    checks++;
    if (enc_err !== 1'b1 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL encerr_set: err=%b valid=%b expected 1/0", enc_err, irq_valid);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0100) begin
      errors++;
      $display("FAIL encerr_hold: valid=%b pend=%b expected 0/0100", irq_valid, pend);
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (enc_err !== 1'b0) begin
      errors++;
      $display("FAIL encerr_clr_priority: err=%b expected 0", enc_err);
    end
    tick();
    checks++;
    if (enc_err !== 1'b1) begin
      errors++;
      $display("FAIL encerr_reassert: err=%b expected 1", enc_err);
    end
    stub_en = 1'b0;
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin
      errors++;
      $display("FAIL encerr_recover: valid=%b id=%0d expected 1/2", irq_valid, irq_id);
    end
    @(posedge clk);
    #3;
    irq_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (irq_valid !== 1'b0 || irq_id !== 2'd0 || pend !== 4'b0000 || enc_err !== 1'b0 ||
        overflow !== 1'b0 || enc_p !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b id=%0d pend=%b err=%b ovf=%b enc_p=%b expected all zero",
               irq_valid, irq_id, pend, enc_err, overflow, enc_p);
    end
    irq_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_quiet: valid=%b pend=%b expected 0/0000", irq_valid, pend);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_priority_order();
    test_mask();
    test_overflow();
    test_set_clr_same();
    test_enc_err_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Four-line request front-end that sits directly upstream of the 4-to-2 priority encoder stage. It synchronises asynchronous request lines, detects their rising edges, and holds them as sticky pending bits. It drives the masked pending vector and enable into the encoder, consumes the encoded index, and issues it to a downstream consumer over a valid/ready handshake. The bit is cleared only when the consumer accepts it.

## Interface
- SYNC_STAGES, 2, flops in each request synchroniser (minimum 2)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_in  input  4  asynchronous request lines, bit n = source n
- mask  input  4  synchronous mask, 1 = source ignored for issue (still latched)
- enc_i  output  4  to encoder i3..i0: pend & ~mask
- enc_p  output  1  to encoder p: |(pend & ~mask)
- enc_o  input  2  encoded index returned by encoder (combinational)
- irq_valid  output  1  index offered downstream
- irq_id  output  2  offered index, stable while irq_valid
- irq_ready  input  1  downstream accept
- pend  output  4  pending register (status)
- overflow  output  1  sticky: edge arrived on an already-pending bit
- enc_err  output  1  sticky: enc_o inconsistent with enc_i
- clr_sticky  input  1  synchronous clear of overflow and enc_err

## Operation
- Reset: all sync flops, edge-history reg, pend, irq_id, overflow and enc_err are 0. irq_valid is 0. State is IDLE.
- Edge detect: rise[n] = sync[n] & ~prev[n]. prev resets to 0, so a line held high through reset yields exactly one pending event.
- pend[n] next = (pend[n] & ~clr[n]) | rise[n]. Set wins over clear in the same cycle, and that case does not flag overflow.
- overflow is set when rise[n] & pend[n] & ~clr[n].
- FSM has two states, IDLE and ISSUE.
- IDLE, with enc_p=1:
  - Validate enc_o: enc_i[enc_o]=1 and all higher enc_i bits are 0.
  - If valid, load irq_id<=enc_o and go to ISSUE.
  - Otherwise set enc_err and stay in IDLE.
- IDLE, with enc_p=0: stay in IDLE.
- ISSUE: irq_valid=1 and irq_id is held.
  - On irq_ready: clr[irq_id]=1 for one cycle, then return to IDLE.
  - Mask changes during ISSUE do not retract the offer.
- clr_sticky has priority over a same-cycle overflow/enc_err set; the clear wins.

## Timing
- req_in rise to pend bit set: SYNC_STAGES+1 cycles.
- pend set to irq_valid high: 1 cycle when in IDLE (registered id load).
- Accept cycle (irq_valid & irq_ready): pend bit cleared and irq_valid low on the next edge.
- Minimum spacing between accepts is 2 cycles: ISSUE, then IDLE re-evaluation with the updated pend.
- irq_valid and irq_id are registered. enc_i and enc_p are combinational from pend and mask only, with no path from irq_ready.
- rst_n asserted mid-handshake: irq_valid drops asynchronously and pend is lost. No accept is inferred.

## Structure
- Shared package holds:
  - NUM_REQ=4
  - ID_W=2
  - state encoding (IDLE=1'b0, ISSUE=1'b1)
- One sub-module: req_sync, an SYNC_STAGES-deep vector synchroniser with async active-low reset, instantiated once at width 4.
- Edge detect, pending, validation and FSM live in the top.

## Test plan
- Reset release with req_in=4'b0100 held: after 3 cycles pend=4'b0100. irq_valid rises next cycle with irq_id=2. Accept gives pend=0 and no further issue.
- req_in pulses 4'b1011 simultaneously, mask=0, with the encoder model in loop: issues in order 3, 1, 0. Each accept clears only that bit, with ≥2 cycles between accepts.
- mask=4'b1000 with pend=4'b1001: issues 0 only. Unmasking bit 3 afterwards: issues 3.
- Second rise on bit 1 while pend[1]=1 and not accepted: overflow=1, pend unchanged. clr_sticky returns overflow to 0.
- Rise on bit 2 in the same cycle that bit 2 is accepted: pend[2] stays 1, overflow stays 0, and bit 2 is reissued.
- Encoder stub returns enc_o=1 for enc_i=4'b0100: enc_err=1, irq_valid stays 0. rst_n pulsed during ISSUE: all outputs return to 0 immediately.
